exe_sequencer: RTL and testbench

//  Issue controller for the 4-lane FP Execution unit. Each op is one func code plus operand vectors.

---
 rtl/exe_pkg.sv | 22 ++
 rtl/exe_sequencer_if.sv | 31 +++
 rtl/exe_seq_operand_mux.sv | 35 +++
 rtl/exe_sequencer.sv | 137 +++++++++++++
 tb/tb_exe_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_pkg.sv
// +----------------------------------------------------------------------------+
// | exe_pkg                                                                     |
// | Shared lane geometry, func encodings and sequencer state type.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package exe_pkg;
  localparam int LANES = 4;
  localparam int W     = 32;

  localparam logic FUNC_CTEPIX  = 1'b1;
  localparam logic FUNC_MULPAIR = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } exe_seq_state_t;
endpackage

`default_nettype wire

// File: rtl/exe_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | exe_seq_if                                                                  |
// | Op-in and result-out valid/ready handshakes of the Execution sequencer.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface exe_seq_if;
  import exe_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_func;
  logic [LANES*W-1:0]   in_a;
  logic [LANES*W-1:0]   in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   out_r;

  modport master (
    output in_valid, in_func, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_r
  );

  modport slave (
    input  in_valid, in_func, in_a, in_b, out_ready,
    output in_ready, out_valid, out_r
  );
endinterface

`default_nettype wire

// File: rtl/exe_seq_operand_mux.sv
// +----------------------------------------------------------------------------+
// | exe_seq_operand_mux                                                         |
// | Routes held operands onto the cte/pix or mul buses by func code.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module exe_seq_operand_mux
  import exe_pkg::*;
(
  input  logic                   i_func,
  input  logic [LANES*W-1:0]     i_a,
  input  logic [LANES*W-1:0]     i_b,
  output logic [LANES*W-1:0]     o_cte,
  output logic [LANES*W-1:0]     o_pix,
  output logic [2*LANES*W-1:0]   o_mul
);

  always_comb begin
    o_cte = '0;
    o_pix = '0;
    o_mul = '0;
    case (i_func)
      FUNC_CTEPIX: begin
        o_cte = i_a;
        o_pix = i_b;
      end
      FUNC_MULPAIR: o_mul = {i_b, i_a};
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/exe_sequencer.sv
// +----------------------------------------------------------------------------+
// | exe_sequencer                                                               |
// | Issue controller holding operands on the unpipelined FP Execution unit for  |
// | EXE_LATENCY cycles, then presenting r1..r4. Optional macro EXE_SEQ_PERF_EN  |
// | adds saturating perf_ops / perf_stall counters.                             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module exe_sequencer
  import exe_pkg::*;
#(
  parameter int EXE_LATENCY = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  exe_seq_if.slave               bus,
  output logic                   exe_func,
  output logic [LANES*W-1:0]     exe_cte,
  output logic [LANES*W-1:0]     exe_pix,
  output logic [2*LANES*W-1:0]   exe_mul,
  input  logic [LANES*W-1:0]     exe_r
`ifdef EXE_SEQ_PERF_EN
  ,
  output logic [31:0]            perf_ops,
  output logic [31:0]            perf_stall
`endif
);

  localparam int              CNT_W  = $clog2(EXE_LATENCY);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(EXE_LATENCY - 1);

  exe_seq_state_t       r_state;
  exe_seq_state_t       w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_func;
  logic [LANES*W-1:0]   r_a;
  logic [LANES*W-1:0]   r_b;
  logic [LANES*W-1:0]   r_out_r;
  logic                 r_out_valid;
  logic                 w_in_ready;
  logic                 w_capture;
  logic                 w_accept;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (r_cnt == c_last) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Retiring and accepting on the same edge avoids an idle bubble.
        if (bus.out_ready) begin
          w_in_ready  = 1'b1;
          w_state_nxt = bus.in_valid ? BUSY : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_func      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_out_r     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_func <= bus.in_func;
        r_a    <= bus.in_a;
        r_b    <= bus.in_b;
        r_cnt  <= '0;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_out_r     <= exe_r;
        r_out_valid <= 1'b1;
      end else if (r_state == DONE && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_r     = r_out_r;
  assign exe_func      = r_func;

  exe_seq_operand_mux u_operand_mux (
    .i_func (r_func),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_cte  (exe_cte),
    .o_pix  (exe_pix),
    .o_mul  (exe_mul)
  );

`ifdef EXE_SEQ_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_ops   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (r_out_valid && bus.out_ready && r_perf_ops != 32'hFFFF_FFFF)
        r_perf_ops <= r_perf_ops + 32'd1;
      if (r_out_valid && !bus.out_ready && r_perf_stall != 32'hFFFF_FFFF)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_ops   = r_perf_ops;
  assign perf_stall = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exe_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_exe_sequencer                                                            |
// | Directed self-checking bench for exe_sequencer (EXE_LATENCY = 16).          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_exe_sequencer;
  import exe_pkg::*;

  localparam int LAT = 16;
  localparam int VW  = LANES * W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            exe_func;
  logic [VW-1:0]   exe_cte;
  logic [VW-1:0]   exe_pix;
  logic [2*VW-1:0] exe_mul;
  logic [VW-1:0]   exe_r;
`ifdef EXE_SEQ_PERF_EN
  logic [31:0]     perf_ops;
  logic [31:0]     perf_stall;
  logic [31:0]     ops0;
`endif

  int tests = 0;
  int fails = 0;

  exe_seq_if bus ();

  exe_sequencer #(.EXE_LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .exe_func (exe_func),
    .exe_cte  (exe_cte),
    .exe_pix  (exe_pix),
    .exe_mul  (exe_mul),
    .exe_r    (exe_r)
`ifdef EXE_SEQ_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [VW-1:0] VA = {32'h409EA10D, 32'h408A9CBB, 32'h4048DC82, 32'h4044F9D2};
  localparam logic [VW-1:0] VB = {32'h42200000, 32'h41F00000, 32'h41A00000, 32'h41200000};
  localparam logic [VW-1:0] K1 = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  localparam logic [VW-1:0] K2 = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h55AA55AA};
  localparam logic [VW-1:0] K3 = {32'h44800000, 32'h44000000, 32'h43800000, 32'h43000000};
  localparam logic [VW-1:0] K4 = {32'hC1200000, 32'hC0A00000, 32'hC0000000, 32'hBF800000};
  localparam logic [VW-1:0] K5 = {32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0};
  localparam logic [VW-1:0] K6 = {32'h3E800000, 32'h3F000000, 32'h3F400000, 32'h3FC00000};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op and wait for the accepting edge.
  task automatic issue(input logic f, input logic [VW-1:0] a, input logic [VW-1:0] b);
    int n;
    n = 0;
    bus.in_func  = f;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("issue_timeout", 256'(n < 50), 256'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Counts edges until out_valid; checks operand buses and in_ready while busy.
  task automatic wait_result(input logic f, input logic [VW-1:0] a, input logic [VW-1:0] b,
                             output int lat, output int bad);
    logic [VW-1:0]   ecte;
    logic [VW-1:0]   epix;
    logic [2*VW-1:0] emul;
    ecte = f ? a : '0;
    epix = f ? b : '0;
    emul = f ? '0 : {b, a};
    lat  = 0;
    bad  = 0;
    do begin
      if (exe_func !== f || exe_cte !== ecte || exe_pix !== epix || exe_mul !== emul
          || bus.in_ready !== 1'b0)
        bad++;
      tick();
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 100);
  endtask

  initial begin
    int lat;
    int bad;
    int acc [3];
    int nacc;
    int cyc;
    int idle;
    logic a_now;

    bus.in_valid  = 1'b0;
    bus.in_func   = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    exe_r         = '0;
    rst           = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_out_valid", 256'(bus.out_valid), 256'd0);
    chk("rst_out_r",     256'(bus.out_r),     256'd0);
    chk("rst_in_ready",  256'(bus.in_ready),  256'd1);
    chk("rst_exe_func",  256'(exe_func),      256'd0);
    chk("rst_exe_cte",   256'(exe_cte),       256'd0);
    chk("rst_exe_pix",   256'(exe_pix),       256'd0);
    chk("rst_exe_mul",   exe_mul,             256'd0);
`ifdef EXE_SEQ_PERF_EN
    chk("rst_perf_ops",   256'(perf_ops),   256'd0);
    chk("rst_perf_stall", 256'(perf_stall), 256'd0);
`endif

    // CTE*PIX op
    exe_r = K1;
    issue(FUNC_CTEPIX, VA, VB);
    wait_result(1'b1, VA, VB, lat, bad);
    chk("ctepix_latency", 256'(lat), 256'(LAT));
    chk("ctepix_stable",  256'(bad), 256'd0);
    chk("ctepix_out_r",   256'(bus.out_r), 256'(K1));
    exe_r = K2;
    bus.out_ready = 1'b1;
    tick();
    chk("ctepix_retire_valid", 256'(bus.out_valid), 256'd0);
    chk("ctepix_retire_out_r", 256'(bus.out_r),     256'(K1));
    chk("ctepix_retire_ready", 256'(bus.in_ready),  256'd1);
    bus.out_ready = 1'b0;

    // MUL-PAIR op, result left pending for the backpressure phase
    exe_r = K3;
    issue(FUNC_MULPAIR, VA, VB);
    chk("mul_lo",   256'(exe_mul[31:0]),    256'h4044F9D2);
    chk("mul_hi",   256'(exe_mul[255:224]), 256'h42200000);
    chk("mul_full", exe_mul,                {VB, VA});
    chk("mul_cte",  256'(exe_cte),          256'd0);
    chk("mul_pix",  256'(exe_pix),          256'd0);
    chk("mul_func", 256'(exe_func),         256'd0);
    wait_result(1'b0, VA, VB, lat, bad);
    chk("mul_latency", 256'(lat), 256'(LAT));
    chk("mul_stable",  256'(bad), 256'd0);
    chk("mul_out_r",   256'(bus.out_r), 256'(K3));

    // Backpressure: exe_r keeps moving, the held result must not
    bad = 0;
    repeat (10) begin
      exe_r = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_r !== K3 || bus.in_ready !== 1'b0) bad++;
    end
    chk("bp_stable",   256'(bad),          256'd0);
    chk("bp_in_ready", 256'(bus.in_ready), 256'd0);
`ifdef EXE_SEQ_PERF_EN
    chk("bp_perf_stall", 256'(perf_stall), 256'd10);
`endif
    bus.out_ready = 1'b1;
    tick();
    chk("bp_retire_valid", 256'(bus.out_valid), 256'd0);
`ifdef EXE_SEQ_PERF_EN
    chk("bp_perf_ops", 256'(perf_ops), 256'd2);
    ops0 = perf_ops;
`endif

    // Back-to-back: one DONE cycle per op, so accepts land LAT+1 edges apart
    exe_r        = K4;
    bus.in_func  = FUNC_CTEPIX;
    bus.in_a     = VA;
    bus.in_b     = VB;
    bus.in_valid = 1'b1;
    nacc = 0;
    cyc  = 0;
    idle = 0;
    while (nacc < 3 && cyc < 200) begin
      a_now = bus.in_ready;
      tick();
      cyc++;
      if (a_now === 1'b1) begin
        acc[nacc] = cyc;
        nacc++;
        if (nacc == 3) bus.in_valid = 1'b0;
      end
      if (nacc > 0 && nacc < 3 && bus.in_ready === 1'b1 && bus.out_valid === 1'b0) idle++;
    end
    chk("b2b_accepts", 256'(nacc), 256'd3);
    chk("b2b_gap1",    256'(acc[1] - acc[0]), 256'(LAT + 1));
    chk("b2b_gap2",    256'(acc[2] - acc[1]), 256'(LAT + 1));
    chk("b2b_no_idle", 256'(idle), 256'd0);
    wait_result(1'b1, VA, VB, lat, bad);
    chk("b2b_latency", 256'(lat), 256'(LAT));
    chk("b2b_out_r",   256'(bus.out_r), 256'(K4));
    tick();
    chk("b2b_retire_valid", 256'(bus.out_valid), 256'd0);
`ifdef EXE_SEQ_PERF_EN
    chk("b2b_perf_ops", 256'(perf_ops - ops0), 256'd3);
`endif

    // Reset mid-op: result of the aborted op must never appear
    bus.out_ready = 1'b0;
    exe_r = K5;
    issue(FUNC_CTEPIX, VA, VB);
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 256'(bus.in_ready), 256'd1);
    chk("abort_exe_cte",  256'(exe_cte),      256'd0);
    tick();
    rst = 1'b0;
    bad = 0;
    repeat (30) begin
      tick();
      if (bus.out_valid !== 1'b0) bad++;
    end
    chk("abort_no_valid", 256'(bad), 256'd0);
    chk("abort_out_r",    256'(bus.out_r), 256'd0);
    exe_r = K6;
    issue(FUNC_CTEPIX, VA, VB);
    wait_result(1'b1, VA, VB, lat, bad);
    chk("after_abort_latency", 256'(lat), 256'(LAT));
    chk("after_abort_out_r",   256'(bus.out_r), 256'(K6));

    // Reset while a result is held drops out_valid without a clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_valid", 256'(bus.out_valid), 256'd0);
    chk("async_out_r",     256'(bus.out_r),     256'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 256'(bus.in_ready), 256'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
